// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell plus a borrow flop, WIDTH+2 cycles per op.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the o_ovf two's-complement overflow output.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for i_start; o_diff/o_borrow hold the previous result
// S_SHIFT | one difference bit per clock, WIDTH clocks
// S_DONE  | o_done strobe for one cycle, then back to S_IDLE
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_bor;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_bnext;
  logic [WIDTH-1:0] w_a_nxt;

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Full-subtractor cell
  assign w_a0    = r_a_sh[0];
  assign w_b0    = r_b_sh[0];
  assign w_d     = w_a0 ^ w_b0 ^ r_bor;
  assign w_bnext = (~w_a0 & w_b0) | (~w_a0 & r_bor) | (w_b0 & r_bor);

  // The minuend register doubles as the result register: each consumed
  // minuend bit is replaced at the top by the freshly computed difference bit.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_a_nxt = w_d;
    end else begin : g_wn
      assign w_a_nxt = {w_d, r_a_sh[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;
  logic w_ovf;

  assign w_ovf = (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_msb <= i_a[WIDTH-1];
        r_b_msb <= i_b[WIDTH-1];
      end
      if (w_last) begin
        r_ovf <= w_ovf;
      end
    end
  end

  assign o_ovf = r_ovf;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_bor    <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_a_sh <= i_a;
      r_b_sh <= i_b;
      r_bor  <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sh <= w_a_nxt;
      r_b_sh <= r_b_sh >> 1;
      r_bor  <= w_bnext;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff   <= w_a_nxt;
        r_borrow <= w_bnext;
      end
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_diff   = r_diff;
  assign o_borrow = r_borrow;

endmodule
